// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions used by the writeback, decode and register file blocks.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // Number of combinational read ports: two source operands per issue slot.
    localparam int NUM_RD_PORTS = 4;

endpackage

// File: rtl/regfile_2w4r_if.sv
// Writeback/decode-side bundle of the dual-issue register file: two write ports, four read ports.
interface regfile_2w4r_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
);

    logic            rf_we0;
    reg_addr_t       rf_waddr0;
    logic [XLEN-1:0] rf_wdata0;
    logic            rf_we1;
    reg_addr_t       rf_waddr1;
    logic [XLEN-1:0] rf_wdata1;

    reg_addr_t       rs1_addr0;
    reg_addr_t       rs2_addr0;
    reg_addr_t       rs1_addr1;
    reg_addr_t       rs2_addr1;
    logic [XLEN-1:0] rs1_data0;
    logic [XLEN-1:0] rs2_data0;
    logic [XLEN-1:0] rs1_data1;
    logic [XLEN-1:0] rs2_data1;

    logic            wr_conflict;

    // Pipeline side: drives writes and read addresses, consumes operands.
    modport master (
        output rf_we0, rf_waddr0, rf_wdata0,
        output rf_we1, rf_waddr1, rf_wdata1,
        output rs1_addr0, rs2_addr0, rs1_addr1, rs2_addr1,
        input  rs1_data0, rs2_data0, rs1_data1, rs2_data1,
        input  wr_conflict
    );

    modport slave (
        input  rf_we0, rf_waddr0, rf_wdata0,
        input  rf_we1, rf_waddr1, rf_wdata1,
        input  rs1_addr0, rs2_addr0, rs1_addr1, rs2_addr1,
        output rs1_data0, rs2_data0, rs1_data1, rs2_data1,
        output wr_conflict
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational register-file read port: x0 hardwiring plus same-cycle write bypass.
module rf_read_port
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int NREGS     = riscv_pkg::NREGS,
    parameter bit BYPASS_EN = 1'b1
) (
    input  reg_addr_t       rd_addr,
    input  logic            we0,
    input  reg_addr_t       waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            we1,
    input  reg_addr_t       waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic [XLEN-1:0] regs [NREGS],
    output logic [XLEN-1:0] rd_data
);

    // Port 1 is checked before port 0 so the bypassed value matches what commits on a collision.
    always_comb begin
        rd_data = regs[rd_addr];
        if (rd_addr == '0) begin
            rd_data = '0;
        end else if (BYPASS_EN && we1 && (waddr1 == rd_addr)) begin
            rd_data = wdata1;
        end else if (BYPASS_EN && we0 && (waddr0 == rd_addr)) begin
            rd_data = wdata0;
        end
    end

endmodule

// File: rtl/regfile_2w4r.sv
// Architectural integer register file: two write ports (slot 1 younger), four combinational read ports.
module regfile_2w4r
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int NREGS     = riscv_pkg::NREGS,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    regfile_2w4r_if.slave      rf
);

    logic [XLEN-1:0] regs [NREGS];
    reg_addr_t       rd_addr [NUM_RD_PORTS];
    logic [XLEN-1:0] rd_data [NUM_RD_PORTS];
    logic            wr_conflict_reg;
    logic            wr_conflict_next;

    genvar gi;

    // Each register owns its flop; x0 is a constant so it never holds state.
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                assign regs[gi] = '0;
            end else begin : g_rw
                localparam reg_addr_t IDX = reg_addr_t'(gi);
                logic [XLEN-1:0] q_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else if (rf.rf_we1 && (rf.rf_waddr1 == IDX)) begin
                        q_reg <= rf.rf_wdata1;
                    end else if (rf.rf_we0 && (rf.rf_waddr0 == IDX)) begin
                        q_reg <= rf.rf_wdata0;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    assign wr_conflict_next = rf.rf_we0 && rf.rf_we1 &&
                              (rf.rf_waddr0 == rf.rf_waddr1) &&
                              (rf.rf_waddr0 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict_reg <= 1'b0;
        end else begin
            wr_conflict_reg <= wr_conflict_next;
        end
    end

    assign rf.wr_conflict = wr_conflict_reg;

    assign rd_addr[0] = rf.rs1_addr0;
    assign rd_addr[1] = rf.rs2_addr0;
    assign rd_addr[2] = rf.rs1_addr1;
    assign rd_addr[3] = rf.rs2_addr1;

    generate
        for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            rf_read_port #(
                .XLEN      (XLEN),
                .NREGS     (NREGS),
                .BYPASS_EN (BYPASS_EN)
            ) u_rd (
                .rd_addr (rd_addr[gi]),
                .we0     (rf.rf_we0),
                .waddr0  (rf.rf_waddr0),
                .wdata0  (rf.rf_wdata0),
                .we1     (rf.rf_we1),
                .waddr1  (rf.rf_waddr1),
                .wdata1  (rf.rf_wdata1),
                .regs    (regs),
                .rd_data (rd_data[gi])
            );
        end
    endgenerate

    assign rf.rs1_data0 = rd_data[0];
    assign rf.rs2_data0 = rd_data[1];
    assign rf.rs1_data1 = rd_data[2];
    assign rf.rs2_data1 = rd_data[3];

endmodule

// File: tb/tb_regfile_2w4r.sv
// Directed scoreboard bench: one DUT with bypass, one without, driven with identical stimulus.
module tb_regfile_2w4r;
    import riscv_pkg::*;

    logic clk;
    logic rst;

    regfile_2w4r_if #(.XLEN(32)) ifb ();
    regfile_2w4r_if #(.XLEN(32)) ifn ();

    regfile_2w4r #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b1)) dut_byp (
        .clk (clk),
        .rst (rst),
        .rf  (ifb)
    );

    regfile_2w4r #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b0)) dut_nob (
        .clk (clk),
        .rst (rst),
        .rf  (ifn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sel: 0-3 bypass DUT read ports, 4-7 non-bypass DUT read ports, 8/9 wr_conflict of each
    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    event check_ev;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0: return ifb.rs1_data0;
            1: return ifb.rs2_data0;
            2: return ifb.rs1_data1;
            3: return ifb.rs2_data1;
            4: return ifn.rs1_data0;
            5: return ifn.rs2_data0;
            6: return ifn.rs1_data1;
            7: return ifn.rs2_data1;
            8: return {31'b0, ifb.wr_conflict};
            9: return {31'b0, ifn.wr_conflict};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compares every queued expectation against the DUT outputs when a sample point is signalled.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(check_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = actual(e.sel);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s sel=%0d got %h expected %h at %0t", e.tag, e.sel, act, e.exp, $time);
                end else begin
                    $display("check %s sel=%0d value %h ok at %0t", e.tag, e.sel, act, $time);
                end
            end
        end
    end

    initial begin
        #20000;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL watchdog: stimulus did not complete within time limit at %0t", $time);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic check_now(input string tag, input int sel, input logic [31:0] exp);
        logic [31:0] act;
        act = actual(sel);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s sel=%0d got %h expected %h at %0t", tag, sel, act, exp, $time);
        end else begin
            $display("check %s sel=%0d value %h ok at %0t", tag, sel, act, $time);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        q.push_back(e);
    endtask

    task automatic expect_all_ports(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 8; i++) expect_val(tag, i, exp);
    endtask

    task automatic settle_check();
        #1;
        ->check_ev;
        #1;
    endtask

    task automatic drive_wr(input logic we0, input reg_addr_t a0, input logic [31:0] d0,
                            input logic we1, input reg_addr_t a1, input logic [31:0] d1);
        ifb.rf_we0 = we0; ifb.rf_waddr0 = a0; ifb.rf_wdata0 = d0;
        ifb.rf_we1 = we1; ifb.rf_waddr1 = a1; ifb.rf_wdata1 = d1;
        ifn.rf_we0 = we0; ifn.rf_waddr0 = a0; ifn.rf_wdata0 = d0;
        ifn.rf_we1 = we1; ifn.rf_waddr1 = a1; ifn.rf_wdata1 = d1;
    endtask

    task automatic drive_rd(input reg_addr_t r10, input reg_addr_t r20,
                            input reg_addr_t r11, input reg_addr_t r21);
        ifb.rs1_addr0 = r10; ifb.rs2_addr0 = r20; ifb.rs1_addr1 = r11; ifb.rs2_addr1 = r21;
        ifn.rs1_addr0 = r10; ifn.rs2_addr0 = r20; ifn.rs1_addr1 = r11; ifn.rs2_addr1 = r21;
    endtask

    initial begin
        rst = 1'b1;
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_rd(5'd0, 5'd5, 5'd31, 5'd31);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        for (int i = 0; i < 8; i++) check_now("reset_read", i, 32'h0);
        check_now("reset_conflict", 8, 32'h0);
        check_now("reset_conflict", 9, 32'h0);

        // Basic dual write to different registers
        @(negedge clk);
        drive_wr(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222);
        drive_rd(5'd3, 5'd0, 5'd0, 5'd7);
        expect_val("dual_wr_bypass_p0", 0, 32'h1111_1111);
        expect_val("dual_wr_bypass_p1", 3, 32'h2222_2222);
        expect_val("dual_wr_nobyp_p0", 4, 32'h0);
        expect_val("dual_wr_nobyp_p1", 7, 32'h0);
        settle_check();
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_val("dual_wr_commit_r3", 0, 32'h1111_1111);
        expect_val("dual_wr_commit_r7", 3, 32'h2222_2222);
        expect_val("dual_wr_commit_r3", 4, 32'h1111_1111);
        expect_val("dual_wr_commit_r7", 7, 32'h2222_2222);
        expect_val("dual_wr_no_conflict", 8, 32'h0);
        expect_val("dual_wr_no_conflict", 9, 32'h0);
        settle_check();

        // Collision on register 10: port 1 wins
        @(negedge clk);
        drive_wr(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd10, 32'hBBBB_0000);
        drive_rd(5'd10, 5'd10, 5'd3, 5'd7);
        expect_val("coll_bypass", 0, 32'hBBBB_0000);
        expect_val("coll_bypass", 1, 32'hBBBB_0000);
        expect_val("coll_nobyp_old", 4, 32'h0);
        expect_val("coll_other_r3", 2, 32'h1111_1111);
        expect_val("coll_conflict_pre", 8, 32'h0);
        settle_check();
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_val("coll_commit", 0, 32'hBBBB_0000);
        expect_val("coll_commit", 4, 32'hBBBB_0000);
        expect_val("coll_conflict_set", 8, 32'h1);
        expect_val("coll_conflict_set", 9, 32'h1);
        settle_check();
        @(negedge clk);
        expect_val("coll_conflict_clear", 8, 32'h0);
        expect_val("coll_conflict_clear", 9, 32'h0);
        settle_check();

        // x0 protection, including both ports targeting x0
        @(negedge clk);
        drive_wr(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hCAFE_F00D);
        drive_rd(5'd0, 5'd0, 5'd0, 5'd0);
        expect_all_ports("x0_same_cycle", 32'h0);
        settle_check();
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_all_ports("x0_after", 32'h0);
        expect_val("x0_no_conflict", 8, 32'h0);
        expect_val("x0_no_conflict", 9, 32'h0);
        settle_check();

        // Bypass versus no bypass on register 4
        @(negedge clk);
        drive_wr(1'b1, 5'd4, 32'h5, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        drive_wr(1'b1, 5'd4, 32'h9, 1'b0, 5'd0, 32'h0);
        drive_rd(5'd0, 5'd0, 5'd4, 5'd0);
        expect_val("byp_new_value", 2, 32'h9);
        expect_val("nobyp_old_value", 6, 32'h5);
        settle_check();
        @(negedge clk);
        // Enables low: addresses and data must be ignored
        drive_wr(1'b0, 5'd4, 32'h0000_FFFF, 1'b0, 5'd4, 32'h0000_EEEE);
        expect_val("byp_next_cycle", 2, 32'h9);
        expect_val("nobyp_next_cycle", 6, 32'h9);
        settle_check();
        @(negedge clk);
        expect_val("we_low_no_commit", 2, 32'h9);
        expect_val("we_low_no_commit", 6, 32'h9);
        settle_check();

        // Asynchronous reset between clock edges
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h0000_1234);
        drive_rd(5'd12, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_val("r12_written", 0, 32'h0000_1234);
        expect_val("r12_written", 4, 32'h0000_1234);
        settle_check();
        #1;
        rst = 1'b1;
        expect_val("async_rst_clear", 0, 32'h0);
        expect_val("async_rst_clear", 4, 32'h0);
        settle_check();
        @(negedge clk);
        rst = 1'b0;
        expect_val("post_rst_r12", 0, 32'h0);
        expect_val("post_rst_r12", 4, 32'h0);
        expect_val("post_rst_conflict", 8, 32'h0);
        settle_check();

        #5;
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
